// File: rtl/cve2_multdiv_iter_pkg.sv
// Shared types and configuration helpers for the iterative multiply/divide
// unit: the operator encoding, the FSM state encoding and the legality check
// for the Width/RadixBits parameter pair.
package cve2_multdiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } multdiv_iter_state_e;

    // Bit r is set when r bits per iteration is a supported radix (1, 2, 4).
    localparam logic [4:0] RadixLegal = 5'b10110;

    function automatic bit multdiv_iter_cfg_ok(input int width, input int radix_bits);
        bit radix_ok;
        radix_ok = (radix_bits >= 1) && (radix_bits <= 4) && RadixLegal[radix_bits];
        return radix_ok && (width >= 8) && ((width % 2) == 0) &&
               ((width % radix_bits) == 0);
    endfunction

endpackage

// File: rtl/cve2_multdiv_iter_if.sv
// Request/result bundle between the EX stage and the iterative multdiv unit.
//   en_i, operator_i, signed_mode_i, op_a_i, op_b_i : request and operands
//   kill_i                                         : abort current operation
//   ready_id_i                                     : consumer takes the result
//   busy_o, valid_o, result_o                      : unit status and result
// The requester uses the master modport, the unit uses the slave modport.
interface cve2_multdiv_iter_if #(
    parameter int Width = 32
);
    import cve2_multdiv_iter_pkg::*;

    logic             en_i;
    md_op_e           operator_i;
    logic [1:0]       signed_mode_i;
    logic [Width-1:0] op_a_i;
    logic [Width-1:0] op_b_i;
    logic             kill_i;
    logic             ready_id_i;
    logic             busy_o;
    logic             valid_o;
    logic [Width-1:0] result_o;

    modport master (
        output en_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_id_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  en_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_id_i,
        output busy_o, valid_o, result_o
    );

endinterface

// File: rtl/cve2_multdiv_iter_step.sv
// One ITER cycle of the multdiv unit, purely combinational.
//   is_div  : 1 = restoring divide steps, 0 = shift-add multiply steps
//   opnd    : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_in  : 2*Width accumulator; multiply keeps {partial product, multiplier},
//             divide keeps the dividend/quotient shift register in the low half
//   rem_in  : Width+1 partial remainder (divide only)
//   acc_out, rem_out : state after RadixBits unrolled steps
module cve2_multdiv_iter_step #(
    parameter int Width     = 32,
    parameter int RadixBits = 1
) (
    input  logic               is_div,
    input  logic [Width-1:0]   opnd,
    input  logic [2*Width-1:0] acc_in,
    input  logic [Width:0]     rem_in,
    output logic [2*Width-1:0] acc_out,
    output logic [Width:0]     rem_out
);

    logic [2*Width-1:0] acc_v;
    logic [Width:0]     rem_v;
    logic [Width:0]     trial;
    logic [Width:0]     sum;
    logic               ge;

    always_comb begin
        acc_v = acc_in;
        rem_v = rem_in;
        trial = '0;
        sum   = '0;
        ge    = 1'b0;
        for (int i = 0; i < RadixBits; i++) begin
            if (is_div) begin
                // Shift the next dividend bit into the remainder; the compare
                // uses the full remainder so no bit of it is silently dropped.
                trial = {rem_v[Width-1:0], acc_v[Width-1]};
                ge    = ({rem_v, acc_v[Width-1]} >= {2'b00, opnd});
                rem_v = ge ? (trial - {1'b0, opnd}) : trial;
                acc_v[Width-1:0] = {acc_v[Width-2:0], ge};
            end else begin
                // Multiplier sits in the low half and is consumed from bit 0;
                // the carry of the add lands in the top bit after the shift.
                sum   = {1'b0, acc_v[2*Width-1:Width]} +
                        {1'b0, (acc_v[0] ? opnd : {Width{1'b0}})};
                acc_v = {sum, acc_v[Width-1:1]};
            end
        end
        acc_out = acc_v;
        rem_out = rem_v;
    end

endmodule

// File: rtl/cve2_multdiv_iter.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/
// REMU) with configurable width and radix and private intermediate state.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of cve2_multdiv_iter_if (request, kill, ready_id,
//            busy/valid/result)
// Flow: accept -> PREP (signs, magnitudes) -> ITER x Width/RadixBits ->
// FIX (sign correction, select) -> DONE (hold until ready_id_i).
module cve2_multdiv_iter
    import cve2_multdiv_iter_pkg::*;
#(
    parameter int Width     = 32,
    parameter int RadixBits = 1
) (
    input logic                clk_i,
    input logic                rst_ni,
    cve2_multdiv_iter_if.slave bus
);

    localparam int Iters = Width / RadixBits;
    localparam int CntW  = $clog2(Iters + 1);
    localparam logic [CntW-1:0] IterLoad = CntW'(Iters);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    if (!multdiv_iter_cfg_ok(Width, RadixBits)) begin : g_bad_cfg
        $error("cve2_multdiv_iter: illegal Width/RadixBits combination");
    end

    function automatic logic [Width-1:0] neg_w(input logic [Width-1:0] v);
        return ~v + {{(Width-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*Width-1:0] neg_2w(input logic [2*Width-1:0] v);
        return ~v + {{(2*Width-1){1'b0}}, 1'b1};
    endfunction

    multdiv_iter_state_e state_q, state_d;

    md_op_e             op_q;
    logic [1:0]         sm_q;
    logic [Width-1:0]   op_a_q;
    logic [Width-1:0]   op_b_q;
    logic [Width-1:0]   opnd_q;
    logic [2*Width-1:0] acc_q;
    logic [Width:0]     rem_q;
    logic [CntW-1:0]    cnt_q;
    logic               sign_res_q;
    logic               div_zero_q;
    logic [Width-1:0]   result_q;

    logic               accept;
    logic               do_prep;
    logic               do_iter;
    logic               do_fix;
    logic               busy;
    logic               valid;

    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [Width-1:0]   mag_a;
    logic [Width-1:0]   mag_b;
    logic [2*Width-1:0] acc_step;
    logic [Width:0]     rem_step;
    logic [2*Width-1:0] prod;
    logic [Width-1:0]   quo;
    logic [Width-1:0]   rmd;
    logic [Width-1:0]   fix_result;

    assign is_div = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    assign sign_a = op_a_q[Width-1] & sm_q[0];
    assign sign_b = op_b_q[Width-1] & sm_q[1];
    // Unsigned Width-bit magnitudes: -2^(Width-1) maps to 2^(Width-1) exactly.
    assign mag_a  = sign_a ? neg_w(op_a_q) : op_a_q;
    assign mag_b  = sign_b ? neg_w(op_b_q) : op_b_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (bus.kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.en_i) state_d = PREP;
                PREP: state_d = (is_div && (op_b_q == '0)) ? FIX : ITER;
                ITER: if (cnt_q == CntOne) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: if (bus.ready_id_i) state_d = bus.en_i ? PREP : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs and datapath strobes ----------------
    always_comb begin
        busy    = (state_q != IDLE);
        valid   = (state_q == DONE);
        accept  = 1'b0;
        do_prep = 1'b0;
        do_iter = 1'b0;
        do_fix  = 1'b0;
        if (!bus.kill_i) begin
            accept  = bus.en_i && ((state_q == IDLE) ||
                                   ((state_q == DONE) && bus.ready_id_i));
            do_prep = (state_q == PREP);
            do_iter = (state_q == ITER);
            do_fix  = (state_q == FIX);
        end
    end

    cve2_multdiv_iter_step #(
        .Width     (Width),
        .RadixBits (RadixBits)
    ) u_step (
        .is_div  (is_div),
        .opnd    (opnd_q),
        .acc_in  (acc_q),
        .rem_in  (rem_q),
        .acc_out (acc_step),
        .rem_out (rem_step)
    );

    // Sign correction and result selection. The divide-by-zero pair is
    // architecturally defined on the raw operands and skips correction.
    always_comb begin
        prod       = sign_res_q ? neg_2w(acc_q) : acc_q;
        quo        = sign_res_q ? neg_w(acc_q[Width-1:0]) : acc_q[Width-1:0];
        rmd        = sign_res_q ? neg_w(rem_q[Width-1:0]) : rem_q[Width-1:0];
        fix_result = prod[Width-1:0];
        case (op_q)
            MD_OP_MULL: fix_result = prod[Width-1:0];
            MD_OP_MULH: fix_result = prod[2*Width-1:Width];
            MD_OP_DIV:  fix_result = div_zero_q ? {Width{1'b1}} : quo;
            MD_OP_REM:  fix_result = div_zero_q ? op_a_q : rmd;
            default:    fix_result = prod[Width-1:0];
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= MD_OP_MULL;
            sm_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            sign_res_q <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.operator_i;
                sm_q   <= bus.signed_mode_i;
                op_a_q <= bus.op_a_i;
                op_b_q <= bus.op_b_i;
            end
            if (do_prep) begin
                sign_res_q <= (op_q == MD_OP_REM) ? sign_a : (sign_a ^ sign_b);
                div_zero_q <= is_div && (op_b_q == '0);
                cnt_q      <= IterLoad;
                rem_q      <= '0;
                if (is_div) begin
                    opnd_q <= mag_b;
                    acc_q  <= {{Width{1'b0}}, mag_a};
                end else begin
                    opnd_q <= mag_a;
                    acc_q  <= {{Width{1'b0}}, mag_b};
                end
            end
            if (do_iter) begin
                acc_q <= acc_step;
                rem_q <= rem_step;
                cnt_q <= cnt_q - CntOne;
            end
            if (do_fix) begin
                result_q <= fix_result;
            end
        end
    end

    assign bus.busy_o   = busy;
    assign bus.valid_o  = valid;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_cve2_multdiv_iter.sv
// Directed bench for cve2_multdiv_iter: one instance at RadixBits=1 and one
// at RadixBits=4, both Width=32, sharing a clock. Expected values are
// hand-computed constants or come from a native-arithmetic reference model.
module tb_cve2_multdiv_iter;
    import cve2_multdiv_iter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cve2_multdiv_iter_if #(.Width(W)) bus1 ();
    cve2_multdiv_iter_if #(.Width(W)) bus4 ();

    cve2_multdiv_iter #(.Width(W), .RadixBits(1)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    cve2_multdiv_iter #(.Width(W), .RadixBits(4)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic en, input md_op_e op,
                           input logic [1:0] sm, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sel == 1) begin
            bus1.en_i = en; bus1.operator_i = op; bus1.signed_mode_i = sm;
            bus1.op_a_i = a; bus1.op_b_i = b;
        end else begin
            bus4.en_i = en; bus4.operator_i = op; bus4.signed_mode_i = sm;
            bus4.op_a_i = a; bus4.op_b_i = b;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 1) bus1.ready_id_i = r; else bus4.ready_id_i = r;
    endtask

    task automatic set_kill(input int sel, input logic k);
        if (sel == 1) bus1.kill_i = k; else bus4.kill_i = k;
    endtask

    function automatic logic vld(input int sel);
        return (sel == 1) ? bus1.valid_o : bus4.valid_o;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 1) ? bus1.busy_o : bus4.busy_o;
    endfunction

    function automatic logic [W-1:0] res(input int sel);
        return (sel == 1) ? bus1.result_o : bus4.result_o;
    endfunction

    // Called #1 after a rising edge with the unit able to accept. Returns the
    // result and the cycle on which valid_o was first seen (accept edge = 0,
    // the cycle right after it = 1), or -1 if valid_o never rose.
    task automatic run_op(input int sel, input md_op_e op, input logic [1:0] sm,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] result, output int cyc);
        set_req(sel, 1'b1, op, sm, a, b);
        @(posedge clk); #1;
        // Scramble inputs after accept; the unit must have registered them.
        set_req(sel, 1'b0, MD_OP_MULL, 2'b00, ~a, ~b);
        cyc = 1;
        while (!vld(sel) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        result = res(sel);
        if (!vld(sel)) cyc = -1;
    endtask

    function automatic logic [W-1:0] model(input md_op_e op, input logic [1:0] sm,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb, p;
        logic [63:0] pu;
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        pa = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
        pb = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
        p  = pa * pb;
        pu = p;
        case (op)
            MD_OP_MULL: return pu[31:0];
            MD_OP_MULH: return pu[63:32];
            MD_OP_DIV: begin
                if (b == 0) return '1;
                if (sm == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    return sa / sb;
                end
                return a / b;
            end
            default: begin
                if (b == 0) return a;
                if (sm == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                    return sa % sb;
                end
                return a % b;
            end
        endcase
    endfunction

    md_op_e     rops [8] = '{MD_OP_MULL, MD_OP_MULH, MD_OP_MULH, MD_OP_MULH,
                             MD_OP_DIV, MD_OP_DIV, MD_OP_REM, MD_OP_REM};
    logic [1:0] rsms [8] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] ra, rb;
        int           cyc;
        int           sel;
        logic         seen;

        set_req(1, 1'b0, MD_OP_MULL, 2'b00, '0, '0);
        set_req(4, 1'b0, MD_OP_MULL, 2'b00, '0, '0);
        set_kill(1, 1'b0); set_kill(4, 1'b0);
        set_ready(1, 1'b1); set_ready(4, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy1",   {31'b0, bsy(1)}, 32'd0);
        check("rst_valid1",  {31'b0, vld(1)}, 32'd0);
        check("rst_result1", res(1), 32'd0);
        check("rst_valid4",  {31'b0, vld(4)}, 32'd0);
        check("rst_result4", res(4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULL 7x6, valid for exactly one cycle
        run_op(1, MD_OP_MULL, 2'b00, 32'd7, 32'd6, r, cyc);
        check("mull_7x6", r, 32'h0000_002A);
        check("mull_lat", cyc, 32'd35);
        @(posedge clk); #1;
        check("mull_valid_drop", {31'b0, vld(1)}, 32'd0);
        check("mull_busy_drop",  {31'b0, bsy(1)}, 32'd0);

        // Signed multiplies
        run_op(1, MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, r, cyc);
        check("mulh_ss", r, 32'h4000_0000);
        run_op(1, MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, cyc);
        check("mulhsu", r, 32'hFFFF_FFFF);

        // Signed divide and overflow
        run_op(1, MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, r, cyc);
        check("div_m7_2", r, 32'hFFFF_FFFD);
        run_op(1, MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, r, cyc);
        check("rem_m7_2", r, 32'hFFFF_FFFF);
        run_op(1, MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, cyc);
        check("div_ovf", r, 32'h8000_0000);
        run_op(1, MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, cyc);
        check("rem_ovf", r, 32'h0000_0000);

        // Divide by zero
        run_op(1, MD_OP_DIV, 2'b00, 32'd5, 32'd0, r, cyc);
        check("divu_5_0", r, 32'hFFFF_FFFF);
        check("divu_0_lat", cyc, 32'd3);
        run_op(1, MD_OP_REM, 2'b11, 32'hFFFF_FFFB, 32'd0, r, cyc);
        check("rem_m5_0", r, 32'hFFFF_FFFB);
        check("rem_0_lat", cyc, 32'd3);
        @(posedge clk); #1;

        // Kill at cycle 10 of a DIVU
        set_req(1, 1'b1, MD_OP_DIV, 2'b00, 32'd1000, 32'd7);
        @(posedge clk); #1;
        set_req(1, 1'b0, MD_OP_MULL, 2'b00, '0, '0);
        repeat (9) @(posedge clk);
        #1;
        check("kill_busy_before", {31'b0, bsy(1)}, 32'd1);
        set_kill(1, 1'b1);
        @(posedge clk); #1;
        set_kill(1, 1'b0);
        check("kill_busy_after", {31'b0, bsy(1)}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (vld(1)) seen = 1'b1;
        end
        check("kill_no_valid", {31'b0, seen}, 32'd0);
        run_op(1, MD_OP_MULL, 2'b00, 32'd3, 32'd3, r, cyc);
        check("post_kill_mull", r, 32'd9);
        check("post_kill_lat", cyc, 32'd35);

        // Hold in DONE with ready low, then back-to-back (R=4)
        set_ready(4, 1'b0);
        run_op(4, MD_OP_MULL, 2'b00, 32'h1234_5678, 32'h10, r, cyc);
        check("r4_mull", r, 32'h2345_6780);
        check("r4_lat", cyc, 32'd11);
        for (int i = 0; i < 5; i++) begin
            set_req(4, 1'b1, MD_OP_DIV, 2'b11, 32'd77 + 32'(i), 32'd3);
            @(posedge clk); #1;
            check($sformatf("hold_result_%0d", i), res(4), 32'h2345_6780);
            check($sformatf("hold_valid_%0d", i), {31'b0, vld(4)}, 32'd1);
        end
        set_ready(4, 1'b1);
        run_op(4, MD_OP_MULL, 2'b00, 32'd100, 32'd200, r, cyc);
        check("b2b_result", r, 32'd20000);
        check("b2b_lat", cyc, 32'd11);

        // Random operands, all eight operator/sign combinations, both radices
        for (int d = 0; d < 2; d++) begin
            sel = (d == 0) ? 1 : 4;
            for (int k = 0; k < 8; k++) begin
                for (int v = 0; v < 2; v++) begin
                    ra = $urandom;
                    rb = (v == 0) ? $urandom : $urandom_range(1, 300);
                    if (rb == 0) rb = 32'd1;
                    run_op(sel, rops[k], rsms[k], ra, rb, r, cyc);
                    check($sformatf("rand_r%0d_k%0d_v%0d a=%h b=%h", sel, k, v, ra, rb),
                          r, model(rops[k], rsms[k], ra, rb));
                    check($sformatf("rand_lat_r%0d_k%0d_v%0d", sel, k, v),
                          cyc, (sel == 1) ? 32'd35 : 32'd11);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
